seg_scan_decoder: RTL and testbench
===================================

Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the multiplexed 4-digit 7-segment driver. Samples the time-multiplexed seg/digit_sel/DP lines and decodes each segment pattern back to BCD.
- Reassembles the 16-bit BCD word and flags each complete scan frame.
- Used as an on-chip display monitor: self-check of the clock display path, and loopback in the board-level bench.

Parameters:
- SETTLE_CYCLES, 4: cycles digit_sel must stay stable and one-hot before a digit is captured (range 1..255).
- TIMEOUT_CYCLES, 1048576: cycles without a completed frame before stale asserts (minimum 16).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- seg  in  7  segment lines {g,f,e,d,c,b,a}, active-low.
- digit_sel  in  4  digit enables, one-hot active-high; bit0 is the least significant digit.
- DP  in  1  decimal point, active-low.
- bcd_out  out  16  last complete frame; nibble i holds the digit selected by digit_sel[i].
- frame_valid  out  1  one-cycle pulse when bcd_out updates.
- err  out  1  last completed frame contained an undecodable pattern.
- stale  out  1  no frame completed within TIMEOUT_CYCLES.

Behaviour:
- Reset values: bcd_out=16'h0, frame_valid=0, err=0, stale=0. Internal state: FSM=IDLE, seen=4'b0, shadow=16'h0, settle and timeout counters=0.
- Input stage: seg, digit_sel and DP are registered once. All logic below uses the registered copies.
- FSM states: IDLE, SETTLE, HOLD.
- IDLE: when digit_sel_r is one-hot, go to SETTLE and load settle_cnt=1.
- SETTLE:
  - If digit_sel_r and seg_r are unchanged from the previous cycle, increment settle_cnt.
  - Any change reloads settle_cnt=1 (a new one-hot value) or returns to IDLE (not one-hot).
  - When settle_cnt reaches SETTLE_CYCLES: write the decoded nibble into shadow[4i+3:4i], set seen[i], OR the invalid flag into frame_err, go to HOLD.
- HOLD: stay until digit_sel_r changes. A new one-hot value goes to SETTLE (settle_cnt=1); anything else goes to IDLE. A changed seg with unchanged digit_sel is ignored until the next select.
- Decode:
  - Patterns for 0-9 map to 0-9, active-low, standard 7-segment shapes.
  - 7'h7F (blank) maps to 4'hF and is not an error.
  - Any other pattern maps to 4'hF and sets invalid.
- Frame completion:
  - The cycle after a capture makes seen==4'b1111: bcd_out<=shadow, err<=frame_err, frame_valid=1 for exactly one cycle.
  - In that same cycle seen and frame_err clear; the shadow register holds its value.
- Re-capture of an already-seen digit before the frame completes overwrites that nibble. seen is unchanged.
- digit_sel of 0000 or multi-hot: never captured, does not clear seen.
- Timeout:
  - The counter increments every cycle and clears on frame_valid.
  - stale=1 when the count reaches TIMEOUT_CYCLES; the counter saturates there.
  - stale=0 on the cycle frame_valid asserts.
- Latency: pin change to capture = 1 (input register) + SETTLE_CYCLES. Capture to frame_valid = 1 cycle.
- Reset mid-frame: all state returns to reset values immediately; a partial frame is discarded.

Optional Feature:
- SEG_SCAN_DP_CAPTURE_EN.
- When defined:
  - Extra port dp_out, out, 4, reset 4'b0.
  - ~DP_r is captured alongside each nibble into a dp shadow register.
  - dp_out updates together with bcd_out on frame_valid.
- When undefined: no port and no DP logic; DP is unused.

Decomposition:
- Package seg7_pkg holds:
  - active-low pattern constants SEG7_0..SEG7_9 and SEG7_BLANK, with values 40,79,24,30,19,12,02,78,00,10,7F hex;
  - the FSM state enum;
  - the digit-count constant 4.
- One combinational sub-module, seg7_to_bcd: seg[6:0] in; nibble[3:0] and invalid out. It is reusable by the bench's scoreboard.

Test Plan:
- Nominal scan: SETTLE_CYCLES=4; each digit held 8 cycles, digits 0..3 = 7'h79,7'h24,7'h30,7'h12 -> bcd_out=16'h5321, frame_valid pulses once, err=0. Capture occurs 5 cycles after each digit_sel change.
- Glitch rejection: digit 2 shows 7'h00 for 2 cycles, then 7'h10 held 8 cycles -> nibble 2 = 9, no error.
- Invalid pattern: digit 1 = 7'h55 -> frame with nibble 1 = F, err=1. The next clean frame gives err=0.
- Illegal select: digit_sel=4'b0110 for 20 cycles mid-scan -> no capture, seen preserved, frame still completes after the remaining digits.
- Stale: TIMEOUT_CYCLES=64, digit_sel held at 4'b0000 -> stale=1 at cycle 64 and stays set. A subsequent full frame clears it with frame_valid.
- Reset mid-frame: rst_n low after 2 digits captured -> outputs zero immediately. The following frame needs all 4 digits before frame_valid.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the 7-segment scan monitor.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

   localparam int SEG7_DIGITS = 4;

   localparam logic [6:0] SEG7_0     = 7'h40;
   localparam logic [6:0] SEG7_1     = 7'h79;
   localparam logic [6:0] SEG7_2     = 7'h24;
   localparam logic [6:0] SEG7_3     = 7'h30;
   localparam logic [6:0] SEG7_4     = 7'h19;
   localparam logic [6:0] SEG7_5     = 7'h12;
   localparam logic [6:0] SEG7_6     = 7'h02;
   localparam logic [6:0] SEG7_7     = 7'h78;
   localparam logic [6:0] SEG7_8     = 7'h00;
   localparam logic [6:0] SEG7_9     = 7'h10;
   localparam logic [6:0] SEG7_BLANK = 7'h7F;

   // Capture FSM: wait for a one-hot select, let it settle, then hold off
   // until the select moves on.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HOLD   = 2'd2
   } scan_state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// seg7_to_bcd: combinational decode of an active-low 7-segment pattern to BCD.
// Blank decodes to 4'hF without error; any unknown shape decodes to 4'hF
// and raises invalid.
module seg7_to_bcd
   import seg7_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] nibble,
   output logic       invalid
);

   // Pattern lookup; defaults cover the blank and unknown cases.
   always_comb begin
      nibble  = 4'hF;
      invalid = 1'b0;
      case (seg)
         SEG7_0:     nibble = 4'd0;
         SEG7_1:     nibble = 4'd1;
         SEG7_2:     nibble = 4'd2;
         SEG7_3:     nibble = 4'd3;
         SEG7_4:     nibble = 4'd4;
         SEG7_5:     nibble = 4'd5;
         SEG7_6:     nibble = 4'd6;
         SEG7_7:     nibble = 4'd7;
         SEG7_8:     nibble = 4'd8;
         SEG7_9:     nibble = 4'd9;
         SEG7_BLANK: nibble = 4'hF;
         default:    invalid = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: samples a multiplexed 4-digit 7-segment display bus,
// decodes each settled digit and publishes complete frames on bcd_out.
// Optional build macro SEG_SCAN_DP_CAPTURE_EN adds dp_out, the decimal
// points captured with each frame (active-high on dp_out).
module seg_scan_decoder
   import seg7_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 1048576
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  seg,
   input  logic [3:0]  digit_sel,
   input  logic        DP,
   output logic [15:0] bcd_out,
   output logic        frame_valid,
   output logic        err,
`ifdef SEG_SCAN_DP_CAPTURE_EN
   output logic [3:0]  dp_out,
`endif
   output logic        stale
);

   localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [7:0]      SETTLE_N = 8'(SETTLE_CYCLES);
   localparam logic [TW-1:0]   TO_MAX   = TW'(TIMEOUT_CYCLES);

   logic [6:0]  seg_r, seg_q;
   logic [3:0]  sel_r, sel_q;
   logic        sel_onehot;
   logic        sel_chg, seg_chg;

   scan_state_t state, state_nxt;
   logic [7:0]  settle_cnt, cnt_nxt;
   logic        capture;

   logic [3:0]  nibble;
   logic        invalid;

   logic [3:0]  seen;
   logic [15:0] shadow;
   logic        frame_err;
   logic        complete;

   logic [TW-1:0] to_cnt;

   // Input register plus a one-cycle-old copy used for change detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_r <= SEG7_BLANK;
         sel_r <= 4'b0;
         seg_q <= SEG7_BLANK;
         sel_q <= 4'b0;
      end else begin
         seg_r <= seg;
         sel_r <= digit_sel;
         seg_q <= seg_r;
         sel_q <= sel_r;
      end
   end

   assign sel_onehot = $onehot(sel_r);
   assign sel_chg    = (sel_r != sel_q);
   assign seg_chg    = (seg_r != seg_q);
   assign complete   = (seen == 4'b1111);

   seg7_to_bcd u_dec (
      .seg     (seg_r),
      .nibble  (nibble),
      .invalid (invalid)
   );

   // FSM state and settle counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         settle_cnt <= 8'd0;
      end else begin
         state      <= state_nxt;
         settle_cnt <= cnt_nxt;
      end
   end

   // Next state: a capture fires on the edge the counter would reach
   // SETTLE_CYCLES, so one-cycle settling captures straight from IDLE/HOLD.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = settle_cnt;
      capture   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (sel_onehot) begin
               state_nxt = ST_SETTLE;
               cnt_nxt   = 8'd1;
            end
         end
         ST_SETTLE: begin
            if (!sel_chg && !seg_chg) begin
               cnt_nxt = settle_cnt + 8'd1;
            end else if (sel_onehot) begin
               cnt_nxt = 8'd1;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_HOLD: begin
            // Segment changes under an unchanged select are ignored here.
            if (sel_chg) begin
               if (sel_onehot) begin
                  state_nxt = ST_SETTLE;
                  cnt_nxt   = 8'd1;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (state_nxt == ST_SETTLE && cnt_nxt == SETTLE_N) begin
         capture   = 1'b1;
         state_nxt = ST_HOLD;
      end
   end

   // Frame assembly: captures fill shadow/seen; a full seen publishes the
   // frame one cycle later and starts the next frame (shadow keeps its data).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seen        <= 4'b0;
         shadow      <= 16'h0;
         frame_err   <= 1'b0;
         bcd_out     <= 16'h0;
         err         <= 1'b0;
         frame_valid <= 1'b0;
      end else begin
         if (complete) begin
            bcd_out     <= shadow;
            err         <= frame_err;
            frame_valid <= 1'b1;
            seen        <= capture ? sel_r : 4'b0;
            frame_err   <= capture & invalid;
         end else begin
            frame_valid <= 1'b0;
            if (capture) begin
               seen      <= seen | sel_r;
               frame_err <= frame_err | invalid;
            end
         end
         for (int i = 0; i < SEG7_DIGITS; i++) begin
            if (capture && sel_r[i]) begin
               shadow[4*i +: 4] <= nibble;
            end
         end
      end
   end

   // Staleness watchdog: counts cycles since the last published frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt <= '0;
         stale  <= 1'b0;
      end else if (complete) begin
         to_cnt <= '0;
         stale  <= 1'b0;
      end else if (to_cnt != TO_MAX) begin
         to_cnt <= to_cnt + 1'b1;
         if (to_cnt == TO_MAX - 1'b1) begin
            stale <= 1'b1;
         end
      end
   end

`ifdef SEG_SCAN_DP_CAPTURE_EN
   logic       dp_r;
   logic [3:0] dp_sh;

   // Decimal points ride along with their digit and publish with the frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dp_r   <= 1'b1;
         dp_sh  <= 4'b0;
         dp_out <= 4'b0;
      end else begin
         dp_r <= DP;
         for (int i = 0; i < SEG7_DIGITS; i++) begin
            if (capture && sel_r[i]) begin
               dp_sh[i] <= ~dp_r;
            end
         end
         if (complete) begin
            dp_out <= dp_sh;
         end
      end
   end
`else
   // DP has no function in this build.
   logic unused_dp;
   assign unused_dp = DP;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: randomized and directed stimulus for seg_scan_decoder,
// checked every cycle against a behavioural model of the display monitor.
module tb_seg_scan_decoder;

   localparam int SETTLE  = 4;
   localparam int TIMEOUT = 64;

   logic        clk;
   logic        rst_n;
   logic [6:0]  seg;
   logic [3:0]  digit_sel;
   logic        DP;
   logic [15:0] bcd_out;
   logic        frame_valid;
   logic        err;
   logic        stale;
`ifdef SEG_SCAN_DP_CAPTURE_EN
   logic [3:0]  dp_out;
`endif

   seg_scan_decoder #(
      .SETTLE_CYCLES  (SETTLE),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seg         (seg),
      .digit_sel   (digit_sel),
      .DP          (DP),
      .bcd_out     (bcd_out),
      .frame_valid (frame_valid),
      .err         (err),
`ifdef SEG_SCAN_DP_CAPTURE_EN
      .dp_out      (dp_out),
`endif
      .stale       (stale)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_errors = 0;
   int fv_count = 0;
   logic [15:0] exp_q[$];
   logic [6:0]  shape_tab [10];

   // Reference model: a digit is accepted once per selection, when the
   // sampled select/pattern pair has been steady for SETTLE samples.
   logic [3:0]  m_p1_sel, m_p2_sel;
   logic [6:0]  m_p1_seg, m_p2_seg;
   logic        m_p1_dp;
   int          m_run;
   bit          m_done;
   logic [3:0]  m_seen;
   logic [15:0] m_shadow;
   logic        m_ferr;
   logic [3:0]  m_dp_sh;
   logic [15:0] m_bcd;
   logic        m_fv, m_err, m_stale;
   logic [3:0]  m_dp_out;
   int          m_to;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [4:0] ref_decode(input logic [6:0] p);
      if (p == 7'h7F) return {1'b0, 4'hF};
      for (int d = 0; d < 10; d++) begin
         if (shape_tab[d] == p) return {1'b0, 4'(d)};
      end
      return {1'b1, 4'hF};
   endfunction

   task automatic model_reset();
      m_p1_sel = 4'b0;  m_p2_sel = 4'b0;
      m_p1_seg = 7'h7F; m_p2_seg = 7'h7F;
      m_p1_dp  = 1'b1;
      m_run = 0; m_done = 0;
      m_seen = 4'b0; m_shadow = 16'h0; m_ferr = 1'b0; m_dp_sh = 4'b0;
      m_bcd = 16'h0; m_fv = 1'b0; m_err = 1'b0; m_stale = 1'b0; m_dp_out = 4'b0;
      m_to = 0;
      exp_q.delete();
   endtask

   // Advance the model by one clock edge on which pins (sel, sg, dp) are sampled.
   task automatic model_step(input logic [3:0] sel, input logic [6:0] sg, input logic dp);
      bit         cap;
      int         idx;
      logic [4:0] dec;
      cap = 0; idx = 0; dec = 5'h0;
      if (!$onehot(m_p1_sel)) begin
         m_run = 0; m_done = 0;
      end else if (m_p1_sel != m_p2_sel) begin
         m_run = 1; m_done = 0;
      end else if (m_p1_seg != m_p2_seg) begin
         if (!m_done) m_run = 1;
      end else begin
         m_run++;
      end
      if (!m_done && m_run == SETTLE) begin
         cap = 1; m_done = 1;
         for (int b = 0; b < 4; b++) if (m_p1_sel[b]) idx = b;
         dec = ref_decode(m_p1_seg);
      end
      if (m_seen == 4'hF) begin
         m_bcd = m_shadow; m_err = m_ferr; m_fv = 1'b1; m_dp_out = m_dp_sh;
         m_stale = 1'b0; m_to = 0;
         exp_q.push_back(m_shadow);
         m_seen = 4'b0; m_ferr = 1'b0;
      end else begin
         m_fv = 1'b0;
         if (m_to < TIMEOUT) m_to++;
         if (m_to == TIMEOUT) m_stale = 1'b1;
      end
      if (cap) begin
         m_seen[idx] = 1'b1;
         m_ferr = m_ferr | dec[4];
         m_shadow[idx*4 +: 4] = dec[3:0];
         m_dp_sh[idx] = ~m_p1_dp;
      end
      m_p2_sel = m_p1_sel; m_p2_seg = m_p1_seg;
      m_p1_sel = sel; m_p1_seg = sg; m_p1_dp = dp;
   endtask

   task automatic compare_outputs();
      check_eq("bcd_out", 32'(bcd_out), 32'(m_bcd));
      check_eq("frame_valid", 32'(frame_valid), 32'(m_fv));
      check_eq("err", 32'(err), 32'(m_err));
      check_eq("stale", 32'(stale), 32'(m_stale));
`ifdef SEG_SCAN_DP_CAPTURE_EN
      check_eq("dp_out", 32'(dp_out), 32'(m_dp_out));
`endif
      if (frame_valid === 1'b1) begin
         fv_count++;
         if (exp_q.size() == 0) check_eq("frame_unexpected", 32'(1), 32'(0));
         else check_eq("frame_bcd", 32'(bcd_out), 32'(exp_q.pop_front()));
      end
   endtask

   // ---------------- driver tasks ----------------
   // Called at a falling edge: drive pins, step the model, check one edge later.
   task automatic tick(input logic [3:0] sel, input logic [6:0] sg, input logic dp);
      digit_sel = sel; seg = sg; DP = dp;
      model_step(sel, sg, dp);
      @(negedge clk);
      compare_outputs();
   endtask

   task automatic drive_digit(input int i, input logic [6:0] pat, input int n);
      logic dp;
      dp = 1'($urandom);
      for (int k = 0; k < n; k++) tick(4'(1 << i), pat, dp);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      digit_sel = 4'b0; seg = 7'h7F; DP = 1'b1;
      #1;
      check_eq("rst_bcd_out", 32'(bcd_out), 32'h0);
      check_eq("rst_frame_valid", 32'(frame_valid), 32'h0);
      check_eq("rst_err", 32'(err), 32'h0);
      check_eq("rst_stale", 32'(stale), 32'h0);
`ifdef SEG_SCAN_DP_CAPTURE_EN
      check_eq("rst_dp_out", 32'(dp_out), 32'h0);
`endif
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int fv_before;
      int fv_at;
      shape_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
      rst_n = 1'b0; digit_sel = 4'b0; seg = 7'h7F; DP = 1'b1;
      model_reset();
      @(negedge clk);
      do_reset();

      // Nominal scan: 1,2,3,5 -> 5321; frame_valid 5 edges after digit 3 select.
      fv_before = fv_count;
      drive_digit(0, 7'h79, 8);
      drive_digit(1, 7'h24, 8);
      drive_digit(2, 7'h30, 8);
      fv_at = -1;
      for (int j = 0; j < 8; j++) begin
         tick(4'b1000, 7'h12, 1'b1);
         if (frame_valid === 1'b1 && fv_at < 0) fv_at = j;
      end
      check_eq("nominal_fv_latency", 32'(fv_at), 32'(5));
      check_eq("nominal_bcd", 32'(bcd_out), 32'h5321);
      check_eq("nominal_err", 32'(err), 32'h0);
      check_eq("nominal_fv_count", 32'(fv_count - fv_before), 32'(1));

      // Glitch rejection on digit 2.
      drive_digit(0, 7'h40, 8);
      drive_digit(1, 7'h79, 8);
      drive_digit(2, 7'h00, 2);
      drive_digit(2, 7'h10, 8);
      drive_digit(3, 7'h30, 8);
      check_eq("glitch_bcd", 32'(bcd_out), 32'h3910);
      check_eq("glitch_err", 32'(err), 32'h0);

      // Undecodable pattern on digit 1, then a clean frame.
      drive_digit(0, 7'h40, 8);
      drive_digit(1, 7'h55, 8);
      drive_digit(2, 7'h24, 8);
      drive_digit(3, 7'h30, 8);
      check_eq("invalid_bcd", 32'(bcd_out), 32'h32F0);
      check_eq("invalid_err", 32'(err), 32'h1);
      for (int i = 0; i < 4; i++) drive_digit(i, 7'h79, 8);
      check_eq("clean_bcd", 32'(bcd_out), 32'h1111);
      check_eq("clean_err", 32'(err), 32'h0);

      // Multi-hot select mid-scan: no capture, partial frame survives.
      fv_before = fv_count;
      drive_digit(0, 7'h24, 8);
      drive_digit(1, 7'h30, 8);
      for (int k = 0; k < 20; k++) tick(4'b0110, 7'h12, 1'b1);
      check_eq("illegal_no_frame", 32'(fv_count - fv_before), 32'(0));
      drive_digit(2, 7'h19, 8);
      drive_digit(3, 7'h12, 8);
      check_eq("illegal_fv_count", 32'(fv_count - fv_before), 32'(1));
      check_eq("illegal_bcd", 32'(bcd_out), 32'h5432);

      // Randomized scanning: mixed holds, blanks, junk, glitches, bad selects.
      repeat (60) begin
         for (int k = 0; k < 5; k++) begin
            int         i;
            int         kind;
            logic [6:0] pat;
            i    = $urandom_range(0, 3);
            kind = $urandom_range(0, 11);
            pat  = shape_tab[$urandom_range(0, 9)];
            if (kind == 8) pat = 7'h7F;
            if (kind == 9) pat = 7'($urandom);
            if (kind == 10) drive_digit(i, 7'($urandom), $urandom_range(1, 3));
            if (kind == 11) begin
               logic [3:0] bad;
               case ($urandom_range(0, 3))
                  0:       bad = 4'b0000;
                  1:       bad = 4'b0110;
                  2:       bad = 4'b1111;
                  default: bad = 4'b1001;
               endcase
               for (int c = 0; c < int'($urandom_range(1, 6)); c++) tick(bad, pat, 1'b1);
            end
            drive_digit(i, pat, $urandom_range(2, 9));
         end
      end

      // Stale: no frames for TIMEOUT cycles after reset.
      @(negedge clk);
      do_reset();
      for (int j = 0; j < 70; j++) begin
         tick(4'b0000, 7'h7F, 1'b1);
         if (j == 62) check_eq("stale_before_limit", 32'(stale), 32'h0);
         if (j == 63) check_eq("stale_at_limit", 32'(stale), 32'h1);
      end
      check_eq("stale_held", 32'(stale), 32'h1);
      drive_digit(0, 7'h40, 8);
      drive_digit(1, 7'h79, 8);
      drive_digit(2, 7'h24, 8);
      drive_digit(3, 7'h30, 8);
      check_eq("stale_cleared", 32'(stale), 32'h0);
      check_eq("stale_frame_bcd", 32'(bcd_out), 32'h3210);

      // Reset mid-frame discards captured digits.
      drive_digit(0, 7'h19, 8);
      drive_digit(1, 7'h12, 8);
      do_reset();
      fv_before = fv_count;
      drive_digit(2, 7'h02, 8);
      drive_digit(3, 7'h78, 8);
      check_eq("rst_partial_no_frame", 32'(fv_count - fv_before), 32'(0));
      drive_digit(0, 7'h00, 8);
      drive_digit(1, 7'h10, 8);
      check_eq("rst_refill_fv_count", 32'(fv_count - fv_before), 32'(1));
      check_eq("rst_refill_bcd", 32'(bcd_out), 32'h7698);

      // ---------------- final report ----------------
      check_eq("exp_q_drained", 32'(exp_q.size()), 32'(0));
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
